// File: rtl/regbank_arb_pkg.sv
// Shared types and constants for the register-bank arbiter.
package regbank_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int REQ_SPI = 0;
  localparam int REQ_I2C = 1;

  // Width of a counter that must be able to hold the value timeout itself.
  function automatic int timeoutCntWidth(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way winner selection: fixed priority to SPI, or round-robin against the
// last-served requester. Purely combinational; the pointer lives in the parent.
module rr_arbiter2
  import regbank_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_prio_mode,
  input  logic       i_last,
  output logic [1:0] o_gnt,
  output logic       o_winner
);

  // Pick the winner; with both requesting, round-robin favours whoever was not served last.
  always_comb begin
    o_gnt    = 2'b00;
    o_winner = 1'(REQ_SPI);
    unique case (i_req)
      2'b01: begin
        o_winner = 1'(REQ_SPI);
        o_gnt    = 2'b01;
      end
      2'b10: begin
        o_winner = 1'(REQ_I2C);
        o_gnt    = 2'b10;
      end
      2'b11: begin
        if (i_prio_mode) begin
          o_winner = 1'(REQ_SPI);
        end else begin
          o_winner = ~i_last;
        end
        o_gnt = o_winner ? 2'b10 : 2'b01;
      end
      default: begin
        o_gnt    = 2'b00;
        o_winner = 1'(REQ_SPI);
      end
    endcase
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Shares one configuration/status register bank between the SPI and I2C host
// interfaces, running one bank access at a time with a bounded wait.
module regbank_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int REG_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                prio_mode,
  input  logic [1:0]          req_i,
  input  logic [1:0]          wr_rdn_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [2*REG_W-1:0]  wdata_i,
  output logic [1:0]          ack_o,
  output logic [1:0]          err_o,
  output logic [REG_W-1:0]    rdata_o,
  output logic [1:0]          gnt_o,
  output logic                bank_wr_rdn,
  output logic [ADDR_W-1:0]   bank_addr,
  output logic [REG_W-1:0]    bank_wdata,
  output logic                bank_we,
  input  logic                bank_ack,
  input  logic                bank_err,
  input  logic [REG_W-1:0]    bank_rdata
);

  localparam int CNT_W = timeoutCntWidth(TIMEOUT);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic [1:0]        r_gnt;
  logic              r_pendErr;
  logic [REG_W-1:0]  r_rdata;
  logic              r_bankWrRdn;
  logic [ADDR_W-1:0] r_bankAddr;
  logic [REG_W-1:0]  r_bankWdata;

  logic [1:0]        w_arbGnt;
  logic              w_arbWinner;
  logic              w_grant;
  logic              w_timeout;
  logic              w_selWrRdn;
  logic [ADDR_W-1:0] w_selAddr;
  logic [REG_W-1:0]  w_selWdata;

  rr_arbiter2 u_arb (
    .i_req       (req_i),
    .i_prio_mode (prio_mode),
    .i_last      (r_last),
    .o_gnt       (w_arbGnt),
    .o_winner    (w_arbWinner)
  );

  assign w_selWrRdn = wr_rdn_i[w_arbWinner];
  assign w_selAddr  = (w_arbWinner == 1'(REQ_I2C)) ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
  assign w_selWdata = (w_arbWinner == 1'(REQ_I2C)) ? wdata_i[2*REG_W-1:REG_W]  : wdata_i[REG_W-1:0];

  assign gnt_o       = r_gnt;
  assign rdata_o     = r_rdata;
  assign bank_wr_rdn = r_bankWrRdn;
  assign bank_addr   = r_bankAddr;
  assign bank_wdata  = r_bankWdata;

  // State register; reset always lands in IDLE, abandoning any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus the per-state strobes; an ack in the last WAIT cycle beats the timeout.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_timeout   = 1'b0;
    bank_we     = 1'b0;
    ack_o       = 2'b00;
    err_o       = 2'b00;
    unique case (r_state)
      IDLE: begin
        if (ena && (req_i != 2'b00)) begin
          w_grant     = 1'b1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        bank_we     = 1'b1;
        w_nextState = WAIT;
      end
      WAIT: begin
        if (bank_ack) begin
          w_nextState = DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        ack_o       = r_gnt;
        err_o       = r_pendErr ? r_gnt : 2'b00;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Grant latch, wait counter and completion capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_gnt       <= 2'b00;
      r_pendErr   <= 1'b0;
      r_rdata     <= '0;
      r_bankWrRdn <= 1'b0;
      r_bankAddr  <= '0;
      r_bankWdata <= '0;
    end else begin
      if (w_grant) begin
        r_gnt       <= w_arbGnt;
        r_last      <= w_arbWinner;
        r_bankWrRdn <= w_selWrRdn;
        r_bankAddr  <= w_selAddr;
        r_bankWdata <= w_selWdata;
      end
      if (r_state == DONE) begin
        r_gnt <= 2'b00;
      end
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if ((r_state == WAIT) && !bank_ack && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == WAIT) && bank_ack) begin
        r_rdata   <= bank_rdata;
        r_pendErr <= bank_err;
      end else if (w_timeout) begin
        r_rdata   <= '0;
        r_pendErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed scenarios followed by a random soak, all
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_regbank_arbiter;

  localparam int REG_W   = 8;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic                ena;
  logic                prio_mode;
  logic [1:0]          req_i;
  logic [1:0]          wr_rdn_i;
  logic [2*ADDR_W-1:0] addr_i;
  logic [2*REG_W-1:0]  wdata_i;
  logic [1:0]          ack_o;
  logic [1:0]          err_o;
  logic [REG_W-1:0]    rdata_o;
  logic [1:0]          gnt_o;
  logic                bank_wr_rdn;
  logic [ADDR_W-1:0]   bank_addr;
  logic [REG_W-1:0]    bank_wdata;
  logic                bank_we;
  logic                bank_ack;
  logic                bank_err;
  logic [REG_W-1:0]    bank_rdata;

  regbank_arbiter #(.REG_W(REG_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .prio_mode  (prio_mode),
    .req_i      (req_i),
    .wr_rdn_i   (wr_rdn_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .rdata_o    (rdata_o),
    .gnt_o      (gnt_o),
    .bank_wr_rdn(bank_wr_rdn),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_we    (bank_we),
    .bank_ack   (bank_ack),
    .bank_err   (bank_err),
    .bank_rdata (bank_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acks   = 0;

  // Requester-side state: a request stays up with fixed payload until acked.
  logic       reqOn[2];
  logic       reqWr[2];
  logic [7:0] reqAddr[2];
  logic [7:0] reqWdata[2];

  // Scenario knobs.
  bit kEna   = 1'b1;
  bit kPrio  = 1'b0;
  bit kRst   = 1'b1;
  int pReq   = 0;
  int pSpur  = 0;
  int kDelay = -1;
  int kRdata = -1;
  int kErr   = -1;

  // Transaction-level reference: one outstanding access with its predicted timeline.
  bit         mBusy = 1'b0;
  int         mGrantCyc = 0;
  int         mDoneCyc = 0;
  int         mDelay = 0;
  int         mWin = 0;
  bit         mPtr = 1'b1;
  bit         mWr = 1'b0;
  logic [7:0] mAddr = 8'h00;
  logic [7:0] mWdata = 8'h00;
  logic [7:0] mRdata = 8'h00;
  bit         mErr = 1'b0;
  int         rstCheckCyc = 1;

  function automatic logic [1:0] oneHot(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic raiseReq(input int r, input bit wr, input logic [7:0] a, input logic [7:0] d);
    reqOn[r]    = 1'b1;
    reqWr[r]    = wr;
    reqAddr[r]  = a;
    reqWdata[r] = d;
  endtask

  // One clock: check the outputs of the current cycle, then drive the next inputs.
  task automatic applyStimulus();
    logic [1:0] expGnt;
    logic [1:0] expAck;
    logic [1:0] expErr;
    int w;
    @(negedge clk);
    cyc++;
    if (mBusy && (cyc > mDoneCyc)) mBusy = 1'b0;

    expGnt = 2'b00;
    expAck = 2'b00;
    expErr = 2'b00;
    if (mBusy && (cyc > mGrantCyc)) expGnt = oneHot(mWin);
    if (mBusy && (cyc == mDoneCyc)) begin
      expAck = oneHot(mWin);
      expErr = mErr ? oneHot(mWin) : 2'b00;
    end
    checkOutput("gnt_o", 32'(gnt_o), 32'(expGnt));
    checkOutput("bank_we", 32'(bank_we), 32'(mBusy && (cyc == mGrantCyc + 1)));
    checkOutput("ack_o", 32'(ack_o), 32'(expAck));
    checkOutput("err_o", 32'(err_o), 32'(expErr));
    if (mBusy && (cyc == mGrantCyc + 1)) begin
      checkOutput("bank_addr", 32'(bank_addr), 32'(mAddr));
      checkOutput("bank_wdata", 32'(bank_wdata), 32'(mWdata));
      checkOutput("bank_wr_rdn", 32'(bank_wr_rdn), 32'(mWr));
    end
    if (expAck != 2'b00) begin
      checkOutput("rdata_o", 32'(rdata_o), 32'(mRdata));
      reqOn[mWin] = 1'b0;
      acks++;
    end
    if (cyc == rstCheckCyc) begin
      checkOutput("rst_rdata", 32'(rdata_o), 32'd0);
      checkOutput("rst_bank_addr", 32'(bank_addr), 32'd0);
      checkOutput("rst_bank_wdata", 32'(bank_wdata), 32'd0);
      checkOutput("rst_bank_wr_rdn", 32'(bank_wr_rdn), 32'd0);
    end

    for (int r = 0; r < 2; r++) begin
      if (!reqOn[r] && ($urandom_range(0, 99) < pReq)) begin
        raiseReq(r, 1'($urandom), 8'($urandom), 8'($urandom));
      end
    end
    if (kRst) begin
      reqOn[0] = 1'b0;
      reqOn[1] = 1'b0;
    end
    rst       = kRst;
    ena       = kEna;
    prio_mode = kPrio;
    req_i     = {reqOn[1], reqOn[0]};
    wr_rdn_i  = {reqWr[1], reqWr[0]};
    addr_i    = {reqAddr[1], reqAddr[0]};
    wdata_i   = {reqWdata[1], reqWdata[0]};

    if (kRst) begin
      mBusy       = 1'b0;
      mPtr        = 1'b1;
      rstCheckCyc = cyc + 1;
    end else if (!mBusy && kEna && (req_i != 2'b00)) begin
      if (req_i == 2'b01)      w = 0;
      else if (req_i == 2'b10) w = 1;
      else if (kPrio)          w = 0;
      else                     w = mPtr ? 0 : 1;
      mBusy     = 1'b1;
      mWin      = w;
      mPtr      = (w == 1);
      mGrantCyc = cyc;
      mWr       = reqWr[w];
      mAddr     = reqAddr[w];
      mWdata    = reqWdata[w];
      if (kDelay >= 0) mDelay = kDelay;
      else mDelay = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      if (mDelay <= TIMEOUT) begin
        mDoneCyc = cyc + 3 + mDelay;
        mRdata   = (kRdata >= 0) ? 8'(kRdata) : 8'($urandom);
        mErr     = (kErr >= 0) ? (kErr != 0) : 1'($urandom);
      end else begin
        mDoneCyc = cyc + 3 + TIMEOUT;
        mRdata   = 8'h00;
        mErr     = 1'b1;
      end
    end

    bank_ack   = 1'b0;
    bank_err   = 1'($urandom);
    bank_rdata = 8'($urandom);
    if (mBusy && (cyc >= mGrantCyc + 2) && (cyc < mDoneCyc)) begin
      if ((mDelay <= TIMEOUT) && (cyc == mGrantCyc + 2 + mDelay)) begin
        bank_ack   = 1'b1;
        bank_err   = mErr;
        bank_rdata = mRdata;
      end
    end else if ($urandom_range(0, 99) < pSpur) begin
      bank_ack = 1'b1;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    int acksBefore;
    reqOn[0] = 1'b0;   reqOn[1] = 1'b0;
    reqWr[0] = 1'b0;   reqWr[1] = 1'b0;
    reqAddr[0] = 8'h00;  reqAddr[1] = 8'h00;
    reqWdata[0] = 8'h00; reqWdata[1] = 8'h00;
    rst = 1'b1; ena = 1'b0; prio_mode = 1'b0;
    req_i = 2'b00; wr_rdn_i = 2'b00; addr_i = '0; wdata_i = '0;
    bank_ack = 1'b0; bank_err = 1'b0; bank_rdata = '0;

    $display("[TB] reset");
    runCycles(2);
    kRst = 1'b0;
    runCycles(1);

    $display("[TB] SPI write, zero-wait bank");
    kDelay = 0; kErr = 0;
    raiseReq(0, 1'b1, 8'h03, 8'hA5);
    runCycles(6);

    $display("[TB] I2C read, two wait cycles");
    kDelay = 2; kRdata = 8'h5C;
    raiseReq(1, 1'b0, 8'h0A, 8'h00);
    runCycles(8);
    kRdata = -1; kErr = -1;

    $display("[TB] both requesting, round-robin then fixed priority");
    kDelay = 0; pReq = 100; kPrio = 1'b0;
    runCycles(20);
    kPrio = 1'b1;
    runCycles(20);
    pReq = 0; kPrio = 1'b0;
    runCycles(10);

    $display("[TB] timeout and last-cycle ack");
    kDelay = 99;
    raiseReq(0, 1'b0, 8'h21, 8'h00);
    runCycles(22);
    kDelay = TIMEOUT;
    raiseReq(1, 1'b0, 8'h22, 8'h00);
    runCycles(22);

    $display("[TB] ena low blocks grants");
    kDelay = 0; kEna = 1'b0;
    raiseReq(0, 1'b1, 8'h40, 8'h11);
    raiseReq(1, 1'b1, 8'h41, 8'h22);
    runCycles(20);
    kEna = 1'b1;
    runCycles(12);

    $display("[TB] req dropped mid-access still acked");
    kDelay = 3;
    raiseReq(1, 1'b1, 8'h55, 8'h66);
    runCycles(3);
    reqOn[1] = 1'b0;
    acksBefore = acks;
    runCycles(6);
    checkOutput("dropped_req_acked", 32'(acks - acksBefore), 32'd1);

    $display("[TB] reset during WAIT");
    kDelay = 10;
    raiseReq(0, 1'b1, 8'h77, 8'h88);
    runCycles(5);
    kRst = 1'b1;
    runCycles(1);
    kRst = 1'b0;
    runCycles(3);
    kDelay = 1;
    raiseReq(0, 1'b1, 8'h78, 8'h99);
    runCycles(8);

    $display("[TB] random soak");
    kDelay = -1; pReq = 30; pSpur = 20;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) kPrio = 1'($urandom);
      kEna = ($urandom_range(0, 19) != 0);
      kRst = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end
    kRst = 1'b0; kEna = 1'b1; pReq = 0;
    runCycles(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Shares the single configuration/status register bank between the two host interfaces: SPI peripheral (requester 0) and I2C peripheral (requester 1).
- Replaces the static select mux between the peripherals and the bank.
- Arbitrates per transaction (round-robin or fixed priority) and sequences one bank access at a time.
- Returns read data, ack and err to the winning requester, and bounds every access with a timeout.

Parameters:
- REG_W, 8, data width of the bank and of both requesters.
- ADDR_W, 8, address width presented by the requesters.
- TIMEOUT, 15, maximum cycles in WAIT before the access is aborted; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ena  in  1  global enable; when 0, no new grant is issued.
- prio_mode  in  1  0 = round-robin, 1 = fixed priority with requester 0 winning.
- req_i  in  2  per-requester request; bit 0 = SPI, bit 1 = I2C.
- wr_rdn_i  in  2  per-requester direction; 1 = write.
- addr_i  in  2*ADDR_W  per-requester address, packed with requester 0 in the LSBs.
- wdata_i  in  2*REG_W  per-requester write data, packed with requester 0 in the LSBs.
- ack_o  out  2  one-cycle completion pulse to the granted requester.
- err_o  out  2  error flag, valid with ack_o.
- rdata_o  out  REG_W  read data, shared by both requesters, valid with ack_o.
- gnt_o  out  2  one-hot current owner; 0 when idle.
- bank_wr_rdn  out  1  direction to the bank.
- bank_addr  out  ADDR_W  address to the bank.
- bank_wdata  out  REG_W  write data to the bank.
- bank_we  out  1  one-cycle access strobe to the bank.
- bank_ack  in  1  bank completion.
- bank_err  in  1  bank error, valid with bank_ack.
- bank_rdata  in  REG_W  bank read data, valid with bank_ack.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; last-served pointer = 1, so requester 0 wins the first round-robin tie.
- Requester protocol:
  - Requester holds req, wr_rdn, addr and wdata stable from assertion until it sees ack.
  - Requester deasserts req at the edge following ack.
- FSM (IDLE, ISSUE, WAIT, DONE):
  - IDLE: if ena=1 and req_i≠0, pick the winner, set gnt_o, latch its wr_rdn/addr/wdata into bank_* registers, then go to ISSUE. Otherwise remain in IDLE.
  - Winner selection:
    - prio_mode=1: requester 0 wins whenever it requests.
    - prio_mode=0 with both requesting: the requester not served last wins.
    - Only one requesting: that requester wins.
    - The last-served pointer updates on every grant, including grants made under prio_mode=1.
  - ISSUE: bank_we=1 for exactly this one cycle; go to WAIT. The timeout counter is cleared here.
  - WAIT:
    - On bank_ack: capture bank_rdata into rdata_o and bank_err into the pending err; go to DONE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT, set rdata_o to 0 and pending err to 1; go to DONE.
    - bank_ack arriving in the same cycle the counter reaches TIMEOUT counts as a normal ack, not a timeout.
  - DONE: ack_o and err_o are driven on the granted bit only, for one cycle. gnt_o clears on exit, then return to IDLE.
- Request and bank handling:
  - Requests are ignored in DONE, so a still-high req cannot be re-granted.
  - bank_ack outside WAIT is ignored.
  - bank_addr, bank_wdata and bank_wr_rdn hold from the IDLE latch until the next grant.
- Latency:
  - Grant to bank_we: 1 cycle.
  - Zero-wait bank (bank_ack in the first WAIT cycle): req seen in IDLE → ack_o 3 cycles later.
  - Maximum: TIMEOUT+3 cycles.
- ena handling:
  - ena=0 only blocks new grants.
  - An in-flight access completes normally.
- prio_mode changes take effect at the next IDLE decision.
- A req that drops mid-transaction does not abort the access; the ack is still pulsed.
- rst asserted in any state forces IDLE and clears all outputs at that edge. No ack is produced for the aborted access.

Decomposition:
- Package regbank_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, DONE}.
  - requester index constants REQ_SPI=0, REQ_I2C=1.
  - TIMEOUT counter width as $clog2(TIMEOUT+1).
- Sub-module rr_arbiter2: combinational winner selection from req, prio_mode and the last-served pointer. The pointer register stays in the parent.

Test Plan:
- Reset, then SPI write addr=0x03 wdata=0xA5, bank_ack in the first WAIT cycle → bank_we one cycle with addr 0x03 / wdata 0xA5; ack_o=01, err_o=00 three cycles after req.
- I2C read addr=0x0A, bank returns 0x5C after 2 wait cycles → rdata_o=0x5C with ack_o=10; gnt_o=10 throughout the transaction.
- Both requesters held continuously, prio_mode=0 → grants alternate 01,10,01,10. With prio_mode=1 → grants are 01 on every transaction.
- bank_ack never asserted, TIMEOUT=15 → ack_o pulses with err_o set and rdata_o=0x00 exactly 18 cycles after the IDLE grant.
- ena=0 with req_i=11 → no bank_we for 20 cycles. Raise ena → grant issued in the first IDLE cycle with ena=1.
- rst pulsed during WAIT → next cycle all outputs 0 and no ack_o. A following SPI request is granted normally.
